tile_fetch_sequencer: RTL and testbench
=======================================

Name: tile_fetch_sequencer

Overview:
- Upstream feeder for the 2-bitplane parallel-to-serial pixel shifter.
- Per scanline, walks COLS tile columns and reads tile code/attribute from tile VRAM, then reads both bitplane bytes from graphics ROM.
- Presents the bitplane bytes with an active-low load pulse every 8 pixel clocks, so the shifter's output is a gapless pixel stream.
- Also supplies the horizontal-flip (reverse) bit and a 4-bit colour attribute aligned to each tile's pixels.

Parameters:
- COLS, 32, tiles per scanline; power of two.
- COL_W, 5, log2(COLS).
- CODE_W, 10, tile code width; ROM_AW = CODE_W+3.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- line_start  in  1  one-cycle pulse that starts fetching a scanline.
- line_num  in  8  current scanline; [7:3] tile row, [2:0] fine row.
- vram_addr  out  5+COL_W  tile VRAM address {tile_row, col}; registered.
- vram_q  in  16  synchronous VRAM data, 1-cycle latency; [15] flipx, [14] flipy, [13:10] colour, [CODE_W-1:0] code.
- rom_addr  out  CODE_W+3  graphics ROM address {code, fine_row'}; registered.
- rom_q1  in  8  ROM bitplane 0, 1-cycle latency.
- rom_q2  in  8  ROM bitplane 1, 1-cycle latency.
- data1  out  8  bitplane 0 byte to shifter.
- data2  out  8  bitplane 1 byte to shifter.
- load  out  1  active-low shifter load; low for exactly one cycle per tile.
- reverse  out  1  horizontal flip for the tile currently being shifted.
- color  out  4  colour attribute for the tile currently being shifted.
- busy  out  1  high while fetching a line.

Behaviour:
- Reset values: vram_addr=0, rom_addr=0, data1=data2=0, load=1, reverse=0, color=0, busy=0. FSM=IDLE, col=0, phase=0.
- Reset mid-line aborts immediately; no further load pulses are issued.
- FSM has two states, IDLE and FETCH, plus a 3-bit phase counter and a COL_W-bit col counter.
- IDLE, line_start=1 at edge E0:
  - latch line_num into line_reg;
  - col=0, phase=0, state=FETCH, busy=1.
- FETCH, per-phase actions at the edge that ends each phase:
  - phase 0: vram_addr <= {line_reg[7:3], col}.
  - phase 2: vram_q is valid; latch code, flipx, flipy, colour into holding registers.
  - phase 3: rom_addr <= {code, line_reg[2:0] XOR {3{flipy}}}.
  - phase 5: rom_q1/rom_q2 are valid; latch into hold1/hold2.
  - phase 6: data1 <= hold1, data2 <= hold2, load <= 0. Load is therefore low throughout phase 7.
  - phase 7: load <= 1; reverse <= held flipx; color <= held colour. The shifter loads on this same edge, so reverse/color change together with the new tile. col <= col+1; phase wraps to 0.
- Phase advances by 1 every clock in FETCH.
- Latency: first load low during cycle E7..E8; shifter captures data at E8. The next tile's load falls exactly 8 cycles later, giving contiguous tiles.
- End of line: after phase 7 of col=COLS-1:
  - state=IDLE, busy=0;
  - data1/data2/reverse/color hold their last values; load stays 1.
  - The shifter drains the last tile, then outputs zeros.
- line_start while in FETCH:
  - restart: relatch line_num, col=0, phase=0;
  - the partial tile is discarded with no load pulse for it;
  - if this coincides with phase 7, the phase-7 load<=1 still applies, and reverse/color still update.
- line_start while in IDLE is the normal start. A line_start coincident with the final phase-7 edge also restarts (stays in FETCH).
- col wraps modulo COLS; it is never compared beyond COLS-1.
- No backpressure; ROM/VRAM must meet the 1-cycle latency.

Test Plan:
- Reset, then idle 20 cycles -> load stays 1, busy 0, all other outputs 0.
- COLS=4, line_num=8'h2B, VRAM models tile r at col c with code=16*r+c, flip 0:
  - vram_addr sequence is 0x14,0x15,0x16,0x17;
  - rom_addr low 3 bits are 3;
  - load low at cycles 8, 16, 24, 32 after line_start;
  - busy falls after cycle 32.
- Tile attribute flipy=1, flipx=1, colour=0xA, line_num[2:0]=2:
  - rom_addr[2:0]=5;
  - reverse=1 and color=0xA assert on the same edge the shifter loads, not before.
- line_start reasserted at phase 4 of col 1 -> no load for the aborted tile; the next load falls 8 cycles after the second line_start, with vram_addr col=0.
- Reset asserted during phase 7 (load=0) -> load returns to 1 asynchronously, busy=0, and no further vram_addr changes occur.
- End-to-end with the pixel shifter: rom_q1=8'hA5, rom_q2=8'h0F, reverse=0 -> shifter out1 serial 1,0,1,0,0,1,0,1 and out2 0,0,0,0,1,1,1,1, with no gap between consecutive tiles.

Source files
------------

// File: rtl/tile_fetch_sequencer.sv
// Tile fetch sequencer: walks one scanline of tiles, fetching VRAM attributes and
// ROM bitplanes, and hands each tile to a 2-bitplane pixel shifter every 8 clocks.
module tile_fetch_sequencer #(
  parameter int unsigned COLS   = 32,
  parameter int unsigned COL_W  = 5,
  parameter int unsigned CODE_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                line_start,
  input  logic [7:0]          line_num,
  output logic [COL_W+4:0]    vram_addr,
  input  logic [15:0]         vram_q,
  output logic [CODE_W+2:0]   rom_addr,
  input  logic [7:0]          rom_q1,
  input  logic [7:0]          rom_q2,
  output logic [7:0]          data1,
  output logic [7:0]          data2,
  output logic                load,
  output logic                reverse,
  output logic [3:0]          color,
  output logic                busy
);

  localparam int unsigned VA_W   = COL_W + 5;
  localparam int unsigned ROM_AW = CODE_W + 3;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t              state_q, state_d;
  logic [2:0]          phase_q, phase_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [7:0]          line_q, line_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                flipx_q, flipx_d;
  logic                flipy_q, flipy_d;
  logic [3:0]          attr_q, attr_d;
  logic [7:0]          hold1_q, hold1_d;
  logic [7:0]          hold2_q, hold2_d;
  logic [VA_W-1:0]     vram_addr_q, vram_addr_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [7:0]          data1_q, data1_d;
  logic [7:0]          data2_q, data2_d;
  logic                load_q, load_d;
  logic                reverse_q, reverse_d;
  logic [3:0]          color_q, color_d;

  // Next-state: one fetch step per phase, tile handed over on the phase-7 edge
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    col_d       = col_q;
    line_d      = line_q;
    code_d      = code_q;
    flipx_d     = flipx_q;
    flipy_d     = flipy_q;
    attr_d      = attr_q;
    hold1_d     = hold1_q;
    hold2_d     = hold2_q;
    vram_addr_d = vram_addr_q;
    rom_addr_d  = rom_addr_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    load_d      = load_q;
    reverse_d   = reverse_q;
    color_d     = color_q;

    if (state_q == FETCH) begin
      phase_d = 3'(phase_q + 3'd1);
      case (phase_q)
        3'd0: vram_addr_d = {line_q[7:3], col_q};
        3'd2: begin
          code_d  = vram_q[CODE_W-1:0];
          flipx_d = vram_q[15];
          flipy_d = vram_q[14];
          attr_d  = vram_q[13:10];
        end
        3'd3: rom_addr_d = {code_q, line_q[2:0] ^ {3{flipy_q}}};
        3'd5: begin
          hold1_d = rom_q1;
          hold2_d = rom_q2;
        end
        3'd6: begin
          // A restart on this edge abandons the tile, so it never gets a load pulse
          if (!line_start) begin
            data1_d = hold1_q;
            data2_d = hold2_q;
            load_d  = 1'b0;
          end
        end
        3'd7: begin
          load_d    = 1'b1;
          reverse_d = flipx_q;
          color_d   = attr_q;
          col_d     = COL_W'(col_q + COL_W'(1));
          if (col_q == COL_W'(COLS - 1)) begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    if (line_start) begin
      line_d  = line_num;
      col_d   = '0;
      phase_d = '0;
      state_d = FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      col_q       <= '0;
      line_q      <= '0;
      code_q      <= '0;
      flipx_q     <= 1'b0;
      flipy_q     <= 1'b0;
      attr_q      <= '0;
      hold1_q     <= '0;
      hold2_q     <= '0;
      vram_addr_q <= '0;
      rom_addr_q  <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      load_q      <= 1'b1;
      reverse_q   <= 1'b0;
      color_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      col_q       <= col_d;
      line_q      <= line_d;
      code_q      <= code_d;
      flipx_q     <= flipx_d;
      flipy_q     <= flipy_d;
      attr_q      <= attr_d;
      hold1_q     <= hold1_d;
      hold2_q     <= hold2_d;
      vram_addr_q <= vram_addr_d;
      rom_addr_q  <= rom_addr_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      load_q      <= load_d;
      reverse_q   <= reverse_d;
      color_q     <= color_d;
    end
  end

  assign vram_addr = vram_addr_q;
  assign rom_addr  = rom_addr_q;
  assign data1     = data1_q;
  assign data2     = data2_q;
  assign load      = load_q;
  assign reverse   = reverse_q;
  assign color     = color_q;
  assign busy      = (state_q == FETCH);

endmodule

// File: tb/tb_tile_fetch_sequencer.sv
// Bench for tile_fetch_sequencer: VRAM/ROM models, a pixel shifter model and a
// load-pulse scoreboard, with scenario tasks run in sequence.
module tb_tile_fetch_sequencer;

  localparam int unsigned COLS   = 4;
  localparam int unsigned COL_W  = 2;
  localparam int unsigned CODE_W = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [7:0]  line_num;
  logic [6:0]  vram_addr;
  logic [15:0] vram_q;
  logic [12:0] rom_addr;
  logic [7:0]  rom_q1, rom_q2;
  logic [7:0]  data1, data2;
  logic        load, reverse, busy;
  logic [3:0]  color;

  tile_fetch_sequencer #(.COLS(COLS), .COL_W(COL_W), .CODE_W(CODE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .line_start(line_start),
    .line_num  (line_num),
    .vram_addr (vram_addr),
    .vram_q    (vram_q),
    .rom_addr  (rom_addr),
    .rom_q1    (rom_q1),
    .rom_q2    (rom_q2),
    .data1     (data1),
    .data2     (data2),
    .load      (load),
    .reverse   (reverse),
    .color     (color),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  // Per-column attributes {flipx, flipy, colour}; code = 16*row + col
  logic [5:0] attr [COLS];
  logic       rom_fixed;

  always @(posedge clk) begin
    vram_q <= {attr[vram_addr[1:0]], CODE_W'(int'(vram_addr[6:2]) * 16 + int'(vram_addr[1:0]))};
    rom_q1 <= rom_fixed ? 8'hA5 : rom_addr[7:0];
    rom_q2 <= rom_fixed ? 8'h0F : rom_addr[12:5];
  end

  // Downstream shifter: parallel load while load is low, otherwise shift
  logic [7:0] sr1, sr2;
  always @(posedge clk) begin
    if (!load) begin
      sr1 <= data1;
      sr2 <= data2;
    end else if (reverse) begin
      sr1 <= sr1 >> 1;
      sr2 <= sr2 >> 1;
    end else begin
      sr1 <= sr1 << 1;
      sr2 <= sr2 << 1;
    end
  end
  wire out1 = reverse ? sr1[0] : sr1[7];
  wire out2 = reverse ? sr2[0] : sr2[7];

  typedef struct {
    int         t;
    logic [6:0] va;
    logic [12:0] ra;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       rev;
    logic [3:0] col;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic       pend;
  logic       prev_rev;
  logic [3:0] prev_col;
  int         checks = 0;
  int         failures = 0;

  task automatic push_line(input logic [7:0] ln, input int t0, input int n);
    exp_t e;
    int r, c, code;
    logic [2:0] fine;
    for (int k = 0; k < n; k++) begin
      c    = k % int'(COLS);
      r    = int'(ln[7:3]);
      fine = attr[c][4] ? (3'd7 - ln[2:0]) : ln[2:0];
      code = 16 * r + c;
      e.t   = t0 + 8 * k + 7;
      e.va  = 7'(r * 4 + c);
      e.ra  = 13'(code * 8 + int'(fine));
      e.d1  = rom_fixed ? 8'hA5 : e.ra[7:0];
      e.d2  = rom_fixed ? 8'h0F : e.ra[12:5];
      e.rev = attr[c][5];
      e.col = attr[c][3:0];
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: pop on each load-low cycle, then check attributes one cycle later
  task automatic sb_sample();
    if (reset) begin
      pend = 1'b0;
      prev_rev = 1'b0;
      prev_col = 4'h0;
    end else if (load === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_load at cycle %0d va=%h", gcyc, vram_addr);
      end else begin
        cur = exp_q.pop_front();
        if (gcyc !== cur.t || vram_addr !== cur.va || rom_addr !== cur.ra || data1 !== cur.d1 ||
            data2 !== cur.d2 || reverse !== prev_rev || color !== prev_col) begin
          failures++;
          $display("FAIL sb_load got t=%0d va=%h ra=%h d=%h/%h rev=%b col=%h required t=%0d va=%h ra=%h d=%h/%h rev=%b col=%h",
                   gcyc, vram_addr, rom_addr, data1, data2, reverse, color,
                   cur.t, cur.va, cur.ra, cur.d1, cur.d2, prev_rev, prev_col);
        end
        pend = 1'b1;
      end
    end else if (pend) begin
      checks++;
      if (reverse !== cur.rev || color !== cur.col) begin
        failures++;
        $display("FAIL sb_attr got rev=%b col=%h required rev=%b col=%h", reverse, color, cur.rev, cur.col);
      end
      prev_rev = cur.rev;
      prev_col = cur.col;
      pend = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_sample();
  endtask

  // Called at a negedge; returns the cycle stamp of the capturing edge
  task automatic start_line(input logic [7:0] ln, input int n, output int t0);
    line_num   = ln;
    line_start = 1'b1;
    @(posedge clk);
    #1;
    t0 = gcyc;
    push_line(ln, t0, n);
    tick();
    line_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    line_start = 1'b0;
    line_num = 8'h00;
    rom_fixed = 1'b0;
    for (int i = 0; i < int'(COLS); i++) attr[i] = 6'h00;
    repeat (2) tick();
    checks++;
    if (load !== 1'b1 || busy !== 1'b0 || vram_addr !== 7'h0 || rom_addr !== 13'h0 ||
        data1 !== 8'h0 || data2 !== 8'h0 || reverse !== 1'b0 || color !== 4'h0) begin
      failures++;
      $display("FAIL reset_values load=%b busy=%b va=%h ra=%h d=%h/%h rev=%b col=%h", load, busy,
               vram_addr, rom_addr, data1, data2, reverse, color);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (load !== 1'b1 || busy !== 1'b0 || vram_addr !== 7'h0 || rom_addr !== 13'h0 ||
          data1 !== 8'h0 || data2 !== 8'h0 || reverse !== 1'b0 || color !== 4'h0) begin
        failures++;
        $display("FAIL idle_values cycle %0d load=%b busy=%b va=%h ra=%h", i, load, busy, vram_addr, rom_addr);
      end
    end
  endtask

  task automatic test_line(input string name, input logic [7:0] ln);
    int t0;
    start_line(ln, int'(COLS), t0);
    for (int i = 0; i < 60 && gcyc < t0 + 40; i++) begin
      tick();
      if (gcyc == t0 + 31) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_last_tile got %b required 1", name, busy);
        end
      end
      if (gcyc == t0 + 32) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL %s busy_end got %b required 0", name, busy);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || load !== 1'b1) begin
      failures++;
      $display("FAIL %s loads_left got %0d load=%b required 0 load=1", name, exp_q.size(), load);
    end
  endtask

  task automatic test_restart();
    int t0, t1;
    start_line(8'h2B, 1, t0);
    for (int i = 0; i < 20 && gcyc < t0 + 12; i++) tick();
    start_line(8'h40, int'(COLS), t1);
    for (int i = 0; i < 80 && busy === 1'b1; i++) tick();
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0 || t1 != t0 + 13) begin
      failures++;
      $display("FAIL restart_end busy=%b left=%0d gap=%0d required busy=0 left=0 gap=13", busy, exp_q.size(), t1 - t0);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    start_line(8'h10, int'(COLS), t0);
    for (int i = 0; i < 40 && gcyc < t0 + 31; i++) tick();
    start_line(8'h18, int'(COLS), t1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_busy got %b required 1", busy);
    end
    for (int i = 0; i < 80 && busy === 1'b1; i++) tick();
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_end busy=%b left=%0d required busy=0 left=0", busy, exp_q.size());
    end
  endtask

  task automatic test_reset_midline();
    int t0;
    start_line(8'h2B, int'(COLS), t0);
    for (int i = 0; i < 20 && load !== 1'b0; i++) tick();
    checks++;
    if (load !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_load got load=%b required 0", load);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (load !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async got load=%b busy=%b required load=1 busy=0", load, busy);
    end
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (load !== 1'b1 || busy !== 1'b0 || vram_addr !== 7'h0) begin
        failures++;
        $display("FAIL midreset_quiet cycle %0d load=%b busy=%b va=%h required 1/0/00", i, load, busy, vram_addr);
      end
    end
  endtask

  task automatic test_shifter();
    int t0, j;
    logic [7:0] p1, p2;
    logic e1, e2;
    p1 = 8'hA5;
    p2 = 8'h0F;
    rom_fixed = 1'b1;
    for (int i = 0; i < int'(COLS); i++) attr[i] = 6'h00;
    start_line(8'h2B, int'(COLS), t0);
    for (int i = 0; i < 20 && gcyc < t0 + 8; i++) tick();
    for (int i = 0; i < 36; i++) begin
      j  = gcyc - (t0 + 8);
      e1 = (j < 32) ? p1[7 - (j % 8)] : 1'b0;
      e2 = (j < 32) ? p2[7 - (j % 8)] : 1'b0;
      checks++;
      if (out1 !== e1 || out2 !== e2) begin
        failures++;
        $display("FAIL shifter_pixel %0d got %b%b required %b%b", j, out1, out2, e1, e2);
      end
      tick();
    end
    rom_fixed = 1'b0;
  endtask

  initial begin
    pend = 1'b0;
    prev_rev = 1'b0;
    prev_col = 4'h0;
    test_reset();
    test_line("basic", 8'h2B);
    attr[0] = {1'b1, 1'b1, 4'hA};
    attr[1] = 6'h00;
    attr[2] = {1'b0, 1'b0, 4'h3};
    attr[3] = {1'b1, 1'b0, 4'h5};
    test_line("flip", 8'h2A);
    for (int i = 0; i < int'(COLS); i++) attr[i] = 6'h00;
    test_restart();
    test_back_to_back();
    test_reset_midline();
    test_shifter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", gcyc);
    $fatal(1, "watchdog");
  end

endmodule
